// File: rtl/net_stream_wrapper.sv
// Valid/ready front-end for the binarised core `top`: assembles an N_IN-bit image from IN_W-bit
// beats, evaluates the core and holds the registered result. Optional counters: NET_STREAM_STATS_EN.

// Stand-in binarised core: each output neuron XNORs the image with a fixed weight
// pattern and fires when more than half of the bits agree.
module top #(
    parameter int N_I = 400,
    parameter int N_O = 8
) (
    input  logic [N_I-1:0] NET_I,
    output logic [N_O-1:0] NET_O
);
    function automatic int agree(input logic [N_I-1:0] v, input int j);
        int n;
        n = 0;
        for (int i = 0; i < N_I; i++)
            if (v[i] == (((i * (2 * j + 3) + j) % 5) < 2)) n++;
        return n;
    endfunction

    always_comb begin
        NET_O = '0;
        for (int j = 0; j < N_O; j++) NET_O[j] = (2 * agree(NET_I, j) > N_I);
    end
endmodule

module net_stream_wrapper #(
    parameter int IN_W     = 16,
    parameter int N_IN     = 400,
    parameter int OUT_W    = 8,
    parameter int EVAL_CYC = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [IN_W-1:0]  s_data,
    input  logic             s_last,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [OUT_W-1:0] m_data,
    output logic             err,
    output logic [15:0]      frame_cnt,
    output logic [15:0]      err_cnt
);
    localparam int BEATS = (N_IN + IN_W - 1) / IN_W;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int EW    = (EVAL_CYC > 1) ? $clog2(EVAL_CYC) : 1;

    typedef enum logic [1:0] {FILL, EVAL, HOLD} state_t;

    state_t           state_q;
    logic [BW-1:0]    beat_q;
    logic [EW-1:0]    eval_q;
    logic [N_IN-1:0]  img_q, img_d;
    logic [OUT_W-1:0] net_o, m_data_q;
    logic             s_ready_q, m_valid_q, err_q;
    logic             beat_acc, last_beat, frame_ok, frame_bad, res_hs;

    assign beat_acc  = s_valid & s_ready_q;
    assign last_beat = (beat_q == BW'(BEATS - 1));
    assign frame_ok  = beat_acc & last_beat & s_last;
    assign frame_bad = beat_acc & (last_beat ^ s_last);
    assign res_hs    = m_valid_q & m_ready;

    // Bits of the final beat that fall beyond N_IN are dropped.
    always_comb begin
        img_d = img_q;
        for (int b = 0; b < IN_W; b++) begin
            if (int'(beat_q) * IN_W + b < N_IN)
                img_d[int'(beat_q) * IN_W + b] = s_data[b];
        end
    end

    top #(.N_I(N_IN), .N_O(OUT_W)) u_core (.NET_I(img_q), .NET_O(net_o));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= FILL;
            beat_q    <= '0;
            eval_q    <= '0;
            img_q     <= '0;
            m_data_q  <= '0;
            s_ready_q <= 1'b1;
            m_valid_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                FILL: if (beat_acc) begin
                    img_q <= img_d;
                    if (frame_ok) begin
                        state_q   <= EVAL;
                        s_ready_q <= 1'b0;
                        beat_q    <= '0;
                        eval_q    <= '0;
                    end else if (frame_bad) begin
                        // Partial image stays in the register; the next frame overwrites it.
                        err_q  <= 1'b1;
                        beat_q <= '0;
                    end else begin
                        beat_q <= beat_q + 1'b1;
                    end
                end
                EVAL: if (eval_q == EW'(EVAL_CYC - 1)) begin
                    m_data_q  <= net_o;
                    m_valid_q <= 1'b1;
                    state_q   <= HOLD;
                end else begin
                    eval_q <= eval_q + 1'b1;
                end
                HOLD: if (res_hs) begin
                    m_valid_q <= 1'b0;
                    s_ready_q <= 1'b1;
                    state_q   <= FILL;
                end
                default: state_q <= FILL;
            endcase
        end
    end

    assign s_ready = s_ready_q;
    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign err     = err_q;

`ifdef NET_STREAM_STATS_EN
    logic [15:0] frame_cnt_q, err_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            if (res_hs && frame_cnt_q != 16'hFFFF) frame_cnt_q <= frame_cnt_q + 16'd1;
            if (err_q && err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
        end
    end

    assign frame_cnt = frame_cnt_q;
    assign err_cnt   = err_cnt_q;
`else
    assign frame_cnt = '0;
    assign err_cnt   = '0;
`endif
endmodule

// File: tb/tb_net_stream_wrapper.sv
// Randomised bench for net_stream_wrapper: default build (16-bit beats) and a 64-bit / 3-cycle eval instance.
module tb_net_stream_wrapper;
    localparam int N_IN = 400, OUT_W = 8, W = 16, W2 = 64, BEATS2 = 7, EV2 = 3;
`ifdef NET_STREAM_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst, s_valid, s_ready, s_last, m_valid, m_ready, err;
    logic [W-1:0]     s_data;
    logic [OUT_W-1:0] m_data;
    logic [15:0]      frame_cnt, err_cnt;
    logic             s_valid2, s_ready2, s_last2, m_valid2, m_ready2, err2;
    logic [W2-1:0]    s_data2;
    logic [OUT_W-1:0] m_data2;
    logic [15:0]      frame_cnt2, err_cnt2;

    int total = 0, bad = 0, exp_frames = 0, exp_errs = 0;

    net_stream_wrapper #(.IN_W(W), .N_IN(N_IN), .OUT_W(OUT_W), .EVAL_CYC(1)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .err(err),
        .frame_cnt(frame_cnt), .err_cnt(err_cnt));

    net_stream_wrapper #(.IN_W(W2), .N_IN(N_IN), .OUT_W(OUT_W), .EVAL_CYC(EV2)) dut2 (
        .clk(clk), .rst(rst), .s_valid(s_valid2), .s_ready(s_ready2), .s_data(s_data2), .s_last(s_last2),
        .m_valid(m_valid2), .m_ready(m_ready2), .m_data(m_data2), .err(err2),
        .frame_cnt(frame_cnt2), .err_cnt(err_cnt2));

    // Reference network: a neuron fires when fewer than half the bits differ from its weights.
    function automatic logic [OUT_W-1:0] ref_core(input logic [N_IN-1:0] v);
        logic [OUT_W-1:0] r;
        logic [N_IN-1:0]  w;
        int               mism;
        r = '0;
        for (int j = 0; j < OUT_W; j++) begin
            for (int i = 0; i < N_IN; i++) w[i] = (((i * (2 * j + 3) + j) % 5) < 2);
            mism = 0;
            for (int i = 0; i < N_IN; i++) mism += int'(v[i] ^ w[i]);
            r[j] = (mism * 2 < N_IN);
        end
        return r;
    endfunction

    function automatic logic [N_IN-1:0] rand_img();
        logic [N_IN-1:0] v;
        for (int i = 0; i < N_IN; i++) v[i] = 1'($urandom_range(0, 1));
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [N_IN-1:0] img, input int nbeats, input int last_at, input bit gaps);
        for (int b = 0; b < nbeats; b++) begin
            if (gaps) while ($urandom_range(0, 2) == 0) begin
                s_valid = 1'b0;
                s_data  = W'($urandom);
                step();
            end
            s_valid = 1'b1;
            s_data  = img[b*W +: W];
            s_last  = (b == last_at);
            total++;
            if (s_ready !== 1'b1) begin
                bad++;
                $display("FAIL s_ready_fill beat=%0d got=%b want=1", b, s_ready);
            end
            step();
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic get_result(input logic [N_IN-1:0] img, input int hold);
        int               lat;
        logic [OUT_W-1:0] exp;
        exp = ref_core(img);
        total++;
        if (s_ready !== 1'b0 || err !== 1'b0) begin
            bad++;
            $display("FAIL after_last s_ready=%b err=%b want 0 0", s_ready, err);
        end
        m_ready = (hold == 0);
        lat = 0;
        while (m_valid !== 1'b1 && lat < 20) begin
            step();
            lat++;
        end
        total++;
        if (lat != 1) begin
            bad++;
            $display("FAIL latency got=%0d want=1", lat);
        end
        total++;
        if (m_data !== exp) begin
            bad++;
            $display("FAIL m_data got=%h want=%h", m_data, exp);
        end
        for (int c = 0; c < hold; c++) begin
            s_valid = 1'b1;
            s_data  = W'($urandom);
            s_last  = 1'($urandom_range(0, 1));
            step();
            total++;
            if (m_valid !== 1'b1 || s_ready !== 1'b0 || m_data !== exp) begin
                bad++;
                $display("FAIL hold c=%0d m_valid=%b s_ready=%b m_data=%h want 1 0 %h", c, m_valid, s_ready, m_data, exp);
            end
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        m_ready = 1'b1;
        step();
        exp_frames++;
        total++;
        if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
            bad++;
            $display("FAIL handshake m_valid=%b s_ready=%b want 0 1", m_valid, s_ready);
        end
        total++;
        if (frame_cnt !== (STATS ? 16'(exp_frames) : 16'd0)) begin
            bad++;
            $display("FAIL frame_cnt got=%0d want=%0d", frame_cnt, STATS ? exp_frames : 0);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        total++;
        if (s_ready !== 1'b1 || m_valid !== 1'b0 || m_data !== '0 || err !== 1'b0) begin
            bad++;
            $display("FAIL %s s_ready=%b m_valid=%b m_data=%h err=%b want 1 0 00 0", tag, s_ready, m_valid, m_data, err);
        end
        total++;
        if (frame_cnt !== 16'd0 || err_cnt !== 16'd0) begin
            bad++;
            $display("FAIL %s_cnt frame_cnt=%0d err_cnt=%0d want 0 0", tag, frame_cnt, err_cnt);
        end
        total++;
        if (s_ready2 !== 1'b1 || m_valid2 !== 1'b0 || m_data2 !== '0 || err2 !== 1'b0) begin
            bad++;
            $display("FAIL %s_wide s_ready=%b m_valid=%b m_data=%h err=%b want 1 0 00 0", tag, s_ready2, m_valid2, m_data2, err2);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        check_idle_outputs("reset");
        rst = 1'b0;
        exp_frames = 0;
        exp_errs   = 0;
    endtask

    task automatic test_single();
        logic [N_IN-1:0] img;
        img = rand_img();
        send_frame(img, 25, 24, 1'b0);
        get_result(img, 0);
    endtask

    task automatic test_back_to_back();
        logic [N_IN-1:0] imgs[4];
        for (int f = 0; f < 4; f++) imgs[f] = rand_img();
        for (int f = 0; f < 4; f++) begin
            send_frame(imgs[f], 25, 24, f[0]);
            get_result(imgs[f], 5);
        end
    endtask

    task automatic check_err_pulse(input string tag);
        total++;
        if (err !== 1'b1) begin
            bad++;
            $display("FAIL %s_err_hi got=%b want=1", tag, err);
        end
        step();
        exp_errs++;
        total++;
        if (err !== 1'b0) begin
            bad++;
            $display("FAIL %s_err_lo got=%b want=0", tag, err);
        end
        total++;
        if (err_cnt !== (STATS ? 16'(exp_errs) : 16'd0)) begin
            bad++;
            $display("FAIL %s_err_cnt got=%0d want=%0d", tag, err_cnt, STATS ? exp_errs : 0);
        end
        for (int c = 0; c < 4; c++) begin
            step();
            total++;
            if (m_valid !== 1'b0 || s_ready !== 1'b1 || err !== 1'b0) begin
                bad++;
                $display("FAIL %s_idle m_valid=%b s_ready=%b err=%b want 0 1 0", tag, m_valid, s_ready, err);
            end
        end
    endtask

    task automatic test_err_early();
        logic [N_IN-1:0] img;
        img = rand_img();
        send_frame(img, 11, 10, 1'b1);
        check_err_pulse("early");
        img = rand_img();
        send_frame(img, 25, 24, 1'b1);
        get_result(img, 2);
    endtask

    task automatic test_err_nolast();
        logic [N_IN-1:0] img;
        img = rand_img();
        send_frame(img, 25, -1, 1'b0);
        check_err_pulse("nolast");
        img = rand_img();
        send_frame(img, 25, 24, 1'b1);
        get_result(img, 0);
    endtask

    task automatic test_reset_mid();
        logic [N_IN-1:0] img;
        int              lat;
        img = rand_img();
        send_frame(img, 12, -1, 1'b1);
        rst = 1'b1;
        step();
        check_idle_outputs("rst_fill");
        rst = 1'b0;
        exp_frames = 0;
        exp_errs   = 0;
        img = rand_img();
        send_frame(img, 25, 24, 1'b0);
        m_ready = 1'b0;
        lat = 0;
        while (m_valid !== 1'b1 && lat < 20) begin
            step();
            lat++;
        end
        rst = 1'b1;
        step();
        check_idle_outputs("rst_hold");
        rst     = 1'b0;
        m_ready = 1'b1;
        img = rand_img();
        send_frame(img, 25, 24, 1'b1);
        get_result(img, 1);
    endtask

    task automatic test_wide();
        logic [N_IN-1:0] img;
        logic [W2-1:0]   word;
        int              lat;
        for (int rep = 0; rep < 2; rep++) begin
            img = rand_img();
            m_ready2 = 1'b1;
            for (int b = 0; b < BEATS2; b++) begin
                word = '1;
                for (int k = 0; k < W2; k++) if (b * W2 + k < N_IN) word[k] = img[b*W2 + k];
                s_valid2 = 1'b1;
                s_data2  = word;
                s_last2  = (b == BEATS2 - 1);
                total++;
                if (s_ready2 !== 1'b1) begin
                    bad++;
                    $display("FAIL wide_s_ready beat=%0d got=%b want=1", b, s_ready2);
                end
                step();
            end
            s_valid2 = 1'b0;
            s_last2  = 1'b0;
            total++;
            if (s_ready2 !== 1'b0) begin
                bad++;
                $display("FAIL wide_s_ready_eval got=%b want=0", s_ready2);
            end
            lat = 0;
            while (m_valid2 !== 1'b1 && lat < 20) begin
                step();
                lat++;
            end
            total++;
            if (lat != EV2) begin
                bad++;
                $display("FAIL wide_latency got=%0d want=%0d", lat, EV2);
            end
            total++;
            if (m_data2 !== ref_core(img)) begin
                bad++;
                $display("FAIL wide_m_data got=%h want=%h", m_data2, ref_core(img));
            end
            step();
            total++;
            if (m_valid2 !== 1'b0 || s_ready2 !== 1'b1) begin
                bad++;
                $display("FAIL wide_handshake m_valid=%b s_ready=%b want 0 1", m_valid2, s_ready2);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b1;
        s_valid2 = 1'b0; s_data2 = '0; s_last2 = 1'b0; m_ready2 = 1'b1;
        test_reset();
        test_single();
        test_back_to_back();
        test_err_early();
        test_err_nolast();
        test_reset_mid();
        test_wide();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
